// File: rtl/nfp_convert_single_to_sfix_pipe.sv
// IEEE-754 single to signed fixed-point converter, three-stage pipeline with a
// global valid/ready advance; denormals convert exactly, NaN/Inf are classified.
module nfp_convert_single_to_sfix_pipe #(
    parameter int OUT_W      = 32,
    parameter int FRAC_W     = 28,
    parameter int ROUND_MODE = 0,
    parameter int SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             nfp_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] nfp_out,
    output logic                    ovf,
    output logic                    nan
);

    // Widest left-shifted magnitude: 24-bit significand shifted by up to 63.
    localparam int MAG_W = 88;
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_W - 1);
    localparam logic [MAG_W-1:0] POS_LIM = NEG_LIM - MAG_W'(1);

    // Scales the significand by 2^sh; right shifts keep the first discarded bit
    // for optional half-away rounding on the magnitude.
    function automatic logic [MAG_W-1:0] shift_round(input logic [23:0] sig,
                                                     input logic signed [9:0] sh);
        logic [MAG_W-1:0] mag;
        logic [24:0]      frac;
        int               shi;
        int               rs;
        mag  = '0;
        frac = '0;
        shi  = int'(sh);
        rs   = 0;
        if (shi >= 0) begin
            if (shi < 64) begin
                mag = MAG_W'(sig) << shi;
            end
        end else begin
            rs   = -shi;
            frac = {sig, 1'b0} >> rs;
            mag  = MAG_W'(frac[24:1]);
            if (ROUND_MODE == 1 && frac[0]) begin
                mag = mag + MAG_W'(1);
            end
        end
        return mag;
    endfunction

    // Applies sign, then clamps or wraps into OUT_W bits; returns {ovf, value}.
    function automatic logic [OUT_W:0] saturate_wrap(input logic             sign,
                                                     input logic             is_nan,
                                                     input logic             is_inf,
                                                     input logic             huge,
                                                     input logic [MAG_W-1:0] mag);
        logic signed [OUT_W-1:0] pos_max;
        logic signed [OUT_W-1:0] neg_min;
        logic signed [OUT_W-1:0] wrapped;
        logic signed [OUT_W-1:0] ext;
        logic                    over;
        pos_max = {1'b0, {(OUT_W-1){1'b1}}};
        neg_min = {1'b1, {(OUT_W-1){1'b0}}};
        ext     = sign ? neg_min : pos_max;
        wrapped = sign ? -$signed(mag[OUT_W-1:0]) : $signed(mag[OUT_W-1:0]);
        over    = huge || (mag > (sign ? NEG_LIM : POS_LIM));
        if (is_nan) begin
            return '0;
        end else if (is_inf) begin
            return {1'b1, ext};
        end else if (over) begin
            return (SATURATE != 0) ? {1'b1, ext} : {1'b1, wrapped};
        end
        return {1'b0, wrapped};
    endfunction

    logic adv;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    logic [7:0]        exp_in;
    logic [22:0]       man_in;
    logic [7:0]        exp_eff;
    logic [23:0]       sig_next;
    logic signed [9:0] sh_next;
    logic              nan_next;
    logic              inf_next;

    always_comb begin
        exp_in   = nfp_in[30:23];
        man_in   = nfp_in[22:0];
        exp_eff  = (exp_in == 8'd0) ? 8'd1 : exp_in;
        sig_next = {exp_in != 8'd0, man_in};
        sh_next  = 10'(int'(exp_eff) - 150 + FRAC_W);
        nan_next = (exp_in == 8'hFF) && (man_in != 23'd0);
        inf_next = (exp_in == 8'hFF) && (man_in == 23'd0);
    end

    // Stage 1: decode and classify
    logic              vld_p0;
    logic              sign_p0;
    logic              nan_p0;
    logic              inf_p0;
    logic [23:0]       sig_p0;
    logic signed [9:0] sh_p0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p0 <= nfp_in[31];
            nan_p0  <= nan_next;
            inf_p0  <= inf_next;
            sig_p0  <= sig_next;
            sh_p0   <= sh_next;
        end
    end

    // Stage 2: shift and round the magnitude
    logic             vld_p1;
    logic             sign_p1;
    logic             nan_p1;
    logic             inf_p1;
    logic             huge_p1;
    logic [MAG_W-1:0] mag_p1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p1 <= sign_p0;
            nan_p1  <= nan_p0;
            inf_p1  <= inf_p0;
            huge_p1 <= (sh_p0 >= 10'sd64) && (sig_p0 != 24'd0);
            mag_p1  <= shift_round(sig_p0, sh_p0);
        end
    end

    // Stage 3: negate, saturate or wrap into the output registers
    logic             vld_p2;
    logic [OUT_W:0]   res_p1;

    always_comb begin
        res_p1 = saturate_wrap(sign_p1, nan_p1, inf_p1, huge_p1, mag_p1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            nfp_out <= '0;
            ovf     <= 1'b0;
            nan     <= 1'b0;
        end else if (adv) begin
            vld_p2  <= vld_p1;
            nfp_out <= $signed(res_p1[OUT_W-1:0]);
            ovf     <= res_p1[OUT_W];
            nan     <= nan_p1;
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_nfp_convert_single_to_sfix_pipe.sv
// Randomised bench for the float-to-fixed pipeline: two parameterisations share
// one stimulus stream and are scored against an exact integer reference model.
module tb_nfp_convert_single_to_sfix_pipe;

    localparam int OUT_W  = 32;
    localparam int FRAC_W = 28;
    localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINN = {1'b1, {(OUT_W-1){1'b0}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              in_valid;
    logic              out_ready;
    logic [31:0]       nfp_in;
    logic              in_ready_a, out_valid_a, ovf_a, nan_a;
    logic              in_ready_b, out_valid_b, ovf_b, nan_b;
    logic [OUT_W-1:0]  out_a, out_b;

    // A: truncate + saturate (defaults).  B: round half away + wrap.
    nfp_convert_single_to_sfix_pipe #(
        .OUT_W(OUT_W), .FRAC_W(FRAC_W), .ROUND_MODE(0), .SATURATE(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .nfp_in(nfp_in), .out_valid(out_valid_a), .out_ready(out_ready),
        .nfp_out(out_a), .ovf(ovf_a), .nan(nan_a)
    );

    nfp_convert_single_to_sfix_pipe #(
        .OUT_W(OUT_W), .FRAC_W(FRAC_W), .ROUND_MODE(1), .SATURATE(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .nfp_in(nfp_in), .out_valid(out_valid_b), .out_ready(out_ready),
        .nfp_out(out_b), .ovf(ovf_b), .nan(nan_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Exact value = significand * 2^(e - 150 + FRAC_W), computed with wide
    // integer multiply/divide; remainder decides rounding.
    task automatic model(input logic [31:0] f, input int rm, input int sat,
                         output logic [OUT_W-1:0] val, output logic o, output logic n);
        logic [255:0] m, d, r, sigw, full, half_lim;
        int e, k;
        n   = 1'b0;
        o   = 1'b0;
        val = '0;
        e   = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                n = 1'b1;
            end else begin
                o   = 1'b1;
                val = f[31] ? MINN : MAXP;
            end
        end else begin
            sigw = 256'(f[22:0]) + ((e != 0) ? 256'd8388608 : 256'd0);
            k    = ((e == 0) ? 1 : e) - 150 + FRAC_W;
            if (k >= 0) begin
                m = sigw * (256'd1 << k);
            end else begin
                d = 256'd1 << (-k);
                m = sigw / d;
                r = sigw % d;
                if (rm == 1 && (2 * r) >= d) m = m + 256'd1;
            end
            half_lim = 256'd1 << (OUT_W - 1);
            o    = f[31] ? (m > half_lim) : (m >= half_lim);
            full = f[31] ? (256'd0 - m) : m;
            if (o && sat == 1) val = f[31] ? MINN : MAXP;
            else               val = full[OUT_W-1:0];
        end
    endtask

    task automatic pin(input string name, input logic [31:0] f, input int rm, input int sat,
                       input logic [OUT_W-1:0] ev, input logic eo, input logic en);
        logic [OUT_W-1:0] v;
        logic o, n;
        model(f, rm, sat, v, o, n);
        check(name, {30'd0, v, o, n}, {30'd0, ev, eo, en});
    endtask

    // Scoreboard: accepted words queued, popped on each output handshake.
    logic [31:0]      q[$];
    logic             stall;
    logic [OUT_W+1:0] held_a, held_b;

    always @(negedge clk) begin
        logic [31:0]      w;
        logic [OUT_W-1:0] va, vb;
        logic             oa, na, ob, nb;
        if (!reset_n) begin
            q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", {63'd0, out_valid_a}, 64'd1);
                check("hold_a", {30'd0, out_a, ovf_a, nan_a}, {30'd0, held_a});
                check("hold_b", {30'd0, out_b, ovf_b, nan_b}, {30'd0, held_b});
            end
            check("valid_b_eq_a", {62'd0, out_valid_b, in_ready_b}, {62'd0, out_valid_a, in_ready_a});
            if (out_valid_a === 1'b1 && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 64'd1, 64'd0);
                end else begin
                    w = q.pop_front();
                    model(w, 0, 1, va, oa, na);
                    model(w, 1, 0, vb, ob, nb);
                    check($sformatf("out_a[%h]", w), {30'd0, out_a, ovf_a, nan_a}, {30'd0, va, oa, na});
                    check($sformatf("out_b[%h]", w), {30'd0, out_b, ovf_b, nan_b}, {30'd0, vb, ob, nb});
                end
            end
            if (in_valid && in_ready_a === 1'b1) q.push_back(nfp_in);
            stall  = (out_valid_a === 1'b1) && !out_ready;
            held_a = {out_a, ovf_a, nan_a};
            held_b = {out_b, ovf_b, nan_b};
        end
    end

    function automatic logic [31:0] rand_word();
        logic s;
        int   c;
        s = 1'($urandom);
        c = $urandom_range(0, 11);
        case (c)
            0:       return {s, 8'hFF, 23'($urandom)};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'h00, 23'($urandom)};
            3:       return {s, 31'd0};
            4:       return $urandom;
            default: return {s, 8'($urandom_range(90, 135)), 23'($urandom)};
        endcase
    endfunction

    task automatic drain();
        int cnt;
        cnt = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && cnt < 50) begin
            @(posedge clk);
            cnt++;
        end
        check("drain_done", 64'(q.size()), 64'd0);
    endtask

    logic [31:0] dir_words [14] = '{
        32'h3F800000, 32'hBFC00000, 32'h41000000, 32'hC1000000, 32'h7FC00000,
        32'hFF800000, 32'h80000000, 32'h00000001, 32'h31000000, 32'hB1000000,
        32'h7F800000, 32'h00000000, 32'hC0FFFFFF, 32'h4F000000
    };

    initial begin
        int n, sent, guard;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nfp_in    = '0;

        pin("m_one",      32'h3F800000, 0, 1, 32'h10000000, 1'b0, 1'b0);
        pin("m_neg1p5",   32'hBFC00000, 0, 1, 32'hE8000000, 1'b0, 1'b0);
        pin("m_eight",    32'h41000000, 0, 1, 32'h7FFFFFFF, 1'b1, 1'b0);
        pin("m_neg8",     32'hC1000000, 0, 1, 32'h80000000, 1'b0, 1'b0);
        pin("m_eight_wr", 32'h41000000, 0, 0, 32'h80000000, 1'b1, 1'b0);
        pin("m_nan",      32'h7FC00000, 0, 1, 32'h00000000, 1'b0, 1'b1);
        pin("m_neginf",   32'hFF800000, 0, 0, 32'h80000000, 1'b1, 1'b0);
        pin("m_negzero",  32'h80000000, 0, 1, 32'h00000000, 1'b0, 1'b0);
        pin("m_denorm",   32'h00000001, 1, 1, 32'h00000000, 1'b0, 1'b0);
        pin("m_tiny_t",   32'h31000000, 0, 1, 32'h00000000, 1'b0, 1'b0);
        pin("m_tiny_r",   32'h31000000, 1, 1, 32'h00000001, 1'b0, 1'b0);
        pin("m_ntiny_t",  32'hB1000000, 0, 1, 32'h00000000, 1'b0, 1'b0);
        pin("m_ntiny_r",  32'hB1000000, 1, 1, 32'hFFFFFFFF, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        check("rst_out_a", {30'd0, out_a, ovf_a, nan_a}, 64'd0);
        check("rst_out_b", {30'd0, out_b, ovf_b, nan_b}, 64'd0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, in_ready_a}, 64'd1);

        // Latency: counted in rising edges from the accepting edge.
        @(posedge clk); #1;
        in_valid = 1'b1;
        nfp_in   = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (out_valid_a !== 1'b1 && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 64'(n), 64'd3);
        drain();

        foreach (dir_words[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            nfp_in   = dir_words[i];
        end
        drain();

        // Ten-word stream under pseudo-random backpressure.
        sent  = 0;
        guard = 0;
        while (sent < 10 && guard < 200) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            nfp_in    = rand_word();
            out_ready = 1'($urandom);
            @(negedge clk);
            if (in_ready_a) sent++;
            guard++;
        end
        check("bp_words_sent", 64'(sent), 64'd10);
        drain();

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            nfp_in    = rand_word();
            out_ready = ($urandom_range(0, 2) != 0);
        end
        drain();

        // Reset with three words in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            nfp_in   = rand_word();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_reset_valid", {62'd0, out_valid_a, out_valid_b}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_idle", {63'd0, out_valid_a}, 64'd0);
        end

        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 1) != 0);
            nfp_in    = rand_word();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
